// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the mips_16 hazard controller.
//   - register address type and default write-back latency
//   - ALU NOP encoding that downstream stages load on a bubble
//   - FSM state encodings (RUN / STALL)
//   - control bundle type and the flush > hazard > run priority resolver
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W     = 3;
  localparam int WB_LATENCY_DEF = 3;
  localparam logic [3:0] ALU_NOP = 4'h0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic flush_if_id;
    logic bubble_ex;
    logic issue;
  } ctrl_t;

  // A taken branch squashes both younger stages, so it wins over a hazard;
  // a hazard holds IF/ID and sends a bubble into EX.
  function automatic ctrl_t resolve_ctrl(input logic branch_taken,
                                         input logic hazard,
                                         input logic id_valid);
    ctrl_t c;
    c = '0;
    if (branch_taken) begin
      c.flush_if_id = 1'b1;
      c.bubble_ex   = 1'b1;
    end else if (hazard) begin
      c.stall_pc    = 1'b1;
      c.stall_if_id = 1'b1;
      c.bubble_ex   = 1'b1;
    end else begin
      c.issue = id_valid;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage / hazard-controller bus.
//   master: ID stage side (drives instruction fields and branch resolution,
//           receives stall/flush/bubble controls)
//   slave : hazard_ctrl
interface hazard_ctrl_if #(parameter int CNT_W = 16) ();
  import hazard_ctrl_pkg::*;

  logic             id_valid;
  reg_addr_t        id_rs1;
  logic             id_rs1_used;
  reg_addr_t        id_rs2;
  logic             id_rs2_used;
  reg_addr_t        id_rd;
  logic             id_wr_en;
  logic             ex_branch_taken;

  logic             stall_pc;
  logic             stall_if_id;
  logic             flush_if_id;
  logic             bubble_ex;
  logic             issue;
  logic             stall_active;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wr_en,
           ex_branch_taken,
    input  stall_pc, stall_if_id, flush_if_id, bubble_ex, issue, stall_active,
           stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_wr_en,
           ex_branch_taken,
    output stall_pc, stall_if_id, flush_if_id, bubble_ex, issue, stall_active,
           stall_count
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// hazard_scoreboard: per-register write-pending counters.
//   clk, rst    : clock, async active-high reset
//   load_en     : an issuing instruction writes load_rd
//   load_rd     : destination register of the issuing instruction
//   rd_addr_a/b : source registers looked up this cycle
//   busy_a/b    : source still waits for a write-back that is not yet visible
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int WB_LATENCY    = WB_LATENCY_DEF,
  parameter int RF_WRITE_THRU = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load_en,
  input  reg_addr_t load_rd,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output logic      busy_a,
  output logic      busy_b
);

  localparam int PEND_W = $clog2(WB_LATENCY + 1);
  localparam int NREG   = 1 << REG_ADDR_W;

  logic [PEND_W-1:0] pend [NREG];
  logic [PEND_W-1:0] pend_a;
  logic [PEND_W-1:0] pend_b;

  // r0 is hard-wired to zero and never tracked. A load of the issuing
  // destination overrides that entry's decrement in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          pend[r] <= '0;
        else if (load_en && (load_rd == reg_addr_t'(r)))
          pend[r] <= PEND_W'(WB_LATENCY);
        else if (pend[r] != '0)
          pend[r] <= pend[r] - PEND_W'(1);
      end
    end
  end

  assign pend_a = pend[rd_addr_a];
  assign pend_b = pend[rd_addr_b];

  // With a write-first register file the final write-back cycle already
  // forwards the value, so a count of 1 is no longer a hazard.
  generate
    if (RF_WRITE_THRU != 0) begin : g_write_thru
      assign busy_a = (pend_a > PEND_W'(1));
      assign busy_b = (pend_b > PEND_W'(1));
    end else begin : g_write_late
      assign busy_a = (pend_a != '0);
      assign busy_b = (pend_b != '0);
    end
  endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the mips_16 core.
// Stalls IF/ID on a read-after-write hazard against EX/MEM/WB and squashes
// IF/ID and ID/EX on a taken branch resolved in EX.
//   clk, rst : clock, async active-high reset
//   bus      : hazard_ctrl_if.slave -- ID instruction fields and branch in,
//              stall_pc/stall_if_id/flush_if_id/bubble_ex/issue (combinational),
//              stall_active/stall_count (registered) out
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WB_LATENCY    = WB_LATENCY_DEF,
  parameter int RF_WRITE_THRU = 1,
  parameter int CNT_W         = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   bus
);

  logic             busy_rs1;
  logic             busy_rs2;
  logic             hazard;
  logic             stall_cyc;
  logic             load_en;
  ctrl_t            ctrl;
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(
    .WB_LATENCY    (WB_LATENCY),
    .RF_WRITE_THRU (RF_WRITE_THRU)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_rd   (bus.id_rd),
    .rd_addr_a (bus.id_rs1),
    .rd_addr_b (bus.id_rs2),
    .busy_a    (busy_rs1),
    .busy_b    (busy_rs2)
  );

  assign hazard = bus.id_valid &
                  ((bus.id_rs1_used & busy_rs1) | (bus.id_rs2_used & busy_rs2));
  assign stall_cyc = hazard & ~bus.ex_branch_taken;

  assign ctrl = resolve_ctrl(bus.ex_branch_taken, hazard, bus.id_valid);

  // Only an instruction that really advances may claim its destination;
  // flushed or bubbled instructions have ctrl.issue low.
  assign load_en = ctrl.issue & bus.id_wr_en & (bus.id_rd != '0);

  assign bus.stall_pc     = ctrl.stall_pc;
  assign bus.stall_if_id  = ctrl.stall_if_id;
  assign bus.flush_if_id  = ctrl.flush_if_id;
  assign bus.bubble_ex    = ctrl.bubble_ex;
  assign bus.issue        = ctrl.issue;
  assign bus.stall_active = (state == ST_STALL);
  assign bus.stall_count  = stall_cnt;

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (stall_cyc) state_next = ST_STALL;
      ST_STALL: if (!stall_cyc) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Saturating so a long-running core never wraps the statistic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_cyc && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl.
// dut0: WB_LATENCY=3, write-first register file, 4-bit stall counter.
// dut1: WB_LATENCY=3, register file without write-through, 16-bit counter.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  hazard_ctrl_if #(.CNT_W(4))  bus0 ();
  hazard_ctrl_if #(.CNT_W(16)) bus1 ();

  hazard_ctrl #(
    .WB_LATENCY    (3),
    .RF_WRITE_THRU (1),
    .CNT_W         (4)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  hazard_ctrl #(
    .WB_LATENCY    (3),
    .RF_WRITE_THRU (0),
    .CNT_W         (16)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [2:0] rs1, input logic rs1u,
                               input logic [2:0] rs2, input logic rs2u,
                               input logic [2:0] rd, input logic wr, input logic br);
    bus0.id_valid        = v;
    bus0.id_rs1          = rs1;
    bus0.id_rs1_used     = rs1u;
    bus0.id_rs2          = rs2;
    bus0.id_rs2_used     = rs2u;
    bus0.id_rd           = rd;
    bus0.id_wr_en        = wr;
    bus0.ex_branch_taken = br;
    #1;
  endtask

  task automatic applyStimulusB(input logic v, input logic [2:0] rs1, input logic rs1u,
                                input logic [2:0] rs2, input logic rs2u,
                                input logic [2:0] rd, input logic wr, input logic br);
    bus1.id_valid        = v;
    bus1.id_rs1          = rs1;
    bus1.id_rs1_used     = rs1u;
    bus1.id_rs2          = rs2;
    bus1.id_rs2_used     = rs2u;
    bus1.id_rd           = rd;
    bus1.id_wr_en        = wr;
    bus1.ex_branch_taken = br;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0);
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_issue", 16'(bus0.issue), 16'd1);
    checkOutput("rst_stall_pc", 16'(bus0.stall_pc), 16'd0);
    checkOutput("rst_stall_active", 16'(bus0.stall_active), 16'd0);
    checkOutput("rst_count", 16'(bus0.stall_count), 16'd0);
    rst = 1'b0;
    tick();

    // RAW back-to-back: pend[3] reads 3 then 2 (stall), then 1 which the
    // write-first register file already serves.
    $display("[TB] RAW back-to-back");
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0);
    checkOutput("raw_issue_producer", 16'(bus0.issue), 16'd1);
    checkOutput("raw_no_stall_producer", 16'(bus0.stall_pc), 16'd0);
    tick();
    applyStimulus(1, 3, 1, 0, 0, 4, 1, 0);
    checkOutput("raw_stall_pc", 16'(bus0.stall_pc), 16'd1);
    checkOutput("raw_stall_if_id", 16'(bus0.stall_if_id), 16'd1);
    checkOutput("raw_bubble_ex", 16'(bus0.bubble_ex), 16'd1);
    checkOutput("raw_issue_blocked", 16'(bus0.issue), 16'd0);
    checkOutput("raw_no_flush", 16'(bus0.flush_if_id), 16'd0);
    tick();
    checkOutput("raw_stall2_pc", 16'(bus0.stall_pc), 16'd1);
    checkOutput("raw_stall_active", 16'(bus0.stall_active), 16'd1);
    checkOutput("raw_count1", 16'(bus0.stall_count), 16'd1);
    tick();
    checkOutput("raw_release_issue", 16'(bus0.issue), 16'd1);
    checkOutput("raw_release_stall_pc", 16'(bus0.stall_pc), 16'd0);
    checkOutput("raw_release_active", 16'(bus0.stall_active), 16'd1);
    checkOutput("raw_count2", 16'(bus0.stall_count), 16'd2);
    tick();

    $display("[TB] r0 destination");
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("r0_issue_producer", 16'(bus0.issue), 16'd1);
    checkOutput("r0_active_cleared", 16'(bus0.stall_active), 16'd0);
    tick();
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("r0_no_stall", 16'(bus0.stall_pc), 16'd0);
    checkOutput("r0_issue", 16'(bus0.issue), 16'd1);
    tick();

    $display("[TB] unused sources");
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0);
    checkOutput("nouse_issue_producer", 16'(bus0.issue), 16'd1);
    tick();
    applyStimulus(1, 3, 0, 4, 1, 0, 0, 0);
    checkOutput("nouse_no_stall", 16'(bus0.stall_pc), 16'd0);
    checkOutput("nouse_issue", 16'(bus0.issue), 16'd1);
    tick();

    $display("[TB] branch beats hazard");
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0);
    checkOutput("br_issue_producer", 16'(bus0.issue), 16'd1);
    tick();
    applyStimulus(1, 0, 0, 5, 1, 6, 1, 1);
    checkOutput("br_flush", 16'(bus0.flush_if_id), 16'd1);
    checkOutput("br_bubble", 16'(bus0.bubble_ex), 16'd1);
    checkOutput("br_stall_pc", 16'(bus0.stall_pc), 16'd0);
    checkOutput("br_stall_if_id", 16'(bus0.stall_if_id), 16'd0);
    checkOutput("br_issue", 16'(bus0.issue), 16'd0);
    tick();
    applyStimulus(1, 6, 1, 0, 0, 0, 0, 0);
    checkOutput("br_rd_not_loaded", 16'(bus0.stall_pc), 16'd0);
    checkOutput("br_next_issue", 16'(bus0.issue), 16'd1);
    checkOutput("br_count_same", 16'(bus0.stall_count), 16'd2);
    checkOutput("br_not_stalled", 16'(bus0.stall_active), 16'd0);
    tick();

    $display("[TB] reset mid-stall");
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0);
    checkOutput("mid_stall_pc", 16'(bus0.stall_pc), 16'd1);
    tick();
    checkOutput("mid_stall_active", 16'(bus0.stall_active), 16'd1);
    checkOutput("mid_count3", 16'(bus0.stall_count), 16'd3);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_stall_pc", 16'(bus0.stall_pc), 16'd0);
    checkOutput("mid_rst_stall_if_id", 16'(bus0.stall_if_id), 16'd0);
    checkOutput("mid_rst_bubble", 16'(bus0.bubble_ex), 16'd0);
    checkOutput("mid_rst_flush", 16'(bus0.flush_if_id), 16'd0);
    checkOutput("mid_rst_issue", 16'(bus0.issue), 16'd1);
    checkOutput("mid_rst_active", 16'(bus0.stall_active), 16'd0);
    checkOutput("mid_rst_count", 16'(bus0.stall_count), 16'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_no_stall", 16'(bus0.stall_pc), 16'd0);
    checkOutput("post_rst_issue", 16'(bus0.issue), 16'd1);
    tick();

    // Self-dependent r2 chain: issue, stall, stall, issue, ... so 9 cycles
    // give 6 stalls and 30 cycles give 20, clamped to 15 by the 4-bit counter.
    $display("[TB] stall counter saturation");
    applyStimulus(1, 2, 1, 0, 0, 2, 1, 0);
    checkOutput("sat_first_issue", 16'(bus0.issue), 16'd1);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("sat_count6", 16'(bus0.stall_count), 16'd6);
    repeat (21) @(posedge clk);
    #1;
    checkOutput("sat_count15", 16'(bus0.stall_count), 16'd15);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("sat_count_hold", 16'(bus0.stall_count), 16'd15);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Without write-through, pend[3]==1 still blocks the read.
    $display("[TB] no write-through");
    applyStimulusB(1, 0, 0, 0, 0, 3, 1, 0);
    checkOutput("nwt_issue_producer", 16'(bus1.issue), 16'd1);
    tick();
    applyStimulusB(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulusB(1, 3, 0, 0, 0, 0, 0, 0);
    checkOutput("nwt_unused_no_stall", 16'(bus1.stall_pc), 16'd0);
    applyStimulusB(1, 3, 1, 0, 0, 0, 0, 0);
    checkOutput("nwt_stall_pc", 16'(bus1.stall_pc), 16'd1);
    checkOutput("nwt_issue_blocked", 16'(bus1.issue), 16'd0);
    tick();
    checkOutput("nwt_release_stall", 16'(bus1.stall_pc), 16'd0);
    checkOutput("nwt_release_issue", 16'(bus1.issue), 16'd1);
    checkOutput("nwt_active", 16'(bus1.stall_active), 16'd1);
    checkOutput("nwt_count1", 16'(bus1.stall_count), 16'd1);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
